// File: rtl/jk_bank_driver.sv
// jk_bank_driver
// Writer side of an external JK flip-flop bank. Accepts a target word over
// a valid/ready handshake, pulses per-bit J/K excitation for one cycle,
// reads Q back, re-drives on mismatch up to MAX_RETRY times and reports
// completion with an error flag.
module jk_bank_driver #(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic             tgt_mode,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             done,
  output logic             err,
  output logic [3:0]       retries
);

  localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] target_r;
  logic             mode_r;
  logic [3:0]       attempts_r;
  logic [WIDTH-1:0] j_r;
  logic [WIDTH-1:0] k_r;
  logic             done_r;
  logic             err_r;
  logic [3:0]       retries_r;
  logic             ready_r;

  logic [2*WIDTH-1:0] accept_exc_s;
  logic [2*WIDTH-1:0] retry_exc_s;
  logic               accept_s;
  logic               match_s;

  // J/K excitation packed as {j, k}. Only bits that must change are driven;
  // set/reset mode drives the target value directly, toggle mode drives J=K=1.
  function automatic logic [2*WIDTH-1:0] excite(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] tgt,
    input logic             md
  );
    logic [WIDTH-1:0] chg;
    chg = cur ^ tgt;
    if (md) begin
      excite = {chg, chg};
    end else begin
      excite = {chg & tgt, chg & ~tgt};
    end
  endfunction

  // Excitation candidates for the accept edge and for a re-drive from CHECK.
  always_comb begin
    accept_exc_s = excite(q, tgt_data, tgt_mode);
    retry_exc_s  = excite(q, target_r, mode_r);
    accept_s     = (state_r == IDLE) && tgt_valid;
    match_s      = (q == target_r);
  end

  // Control FSM with all outputs registered; done/err default low so they
  // pulse for exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      target_r   <= '0;
      mode_r     <= 1'b0;
      attempts_r <= 4'd0;
      j_r        <= '0;
      k_r        <= '0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      retries_r  <= 4'd0;
      ready_r    <= 1'b1;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            target_r   <= tgt_data;
            mode_r     <= tgt_mode;
            attempts_r <= 4'd0;
            {j_r, k_r} <= accept_exc_s;
            ready_r    <= 1'b0;
            state_r    <= DRIVE;
          end else begin
            j_r     <= '0;
            k_r     <= '0;
            ready_r <= 1'b1;
          end
        end
        DRIVE: begin
          // Bank samples j/k at this edge; stop driving immediately after.
          j_r     <= '0;
          k_r     <= '0;
          state_r <= CHECK;
        end
        CHECK: begin
          if (match_s) begin
            done_r    <= 1'b1;
            err_r     <= 1'b0;
            retries_r <= attempts_r;
            ready_r   <= 1'b1;
            state_r   <= IDLE;
          end else if (attempts_r < MAX_RETRY_C) begin
            attempts_r <= attempts_r + 4'd1;
            {j_r, k_r} <= retry_exc_s;
            state_r    <= DRIVE;
          end else begin
            done_r    <= 1'b1;
            err_r     <= 1'b1;
            retries_r <= attempts_r;
            ready_r   <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          j_r     <= '0;
          k_r     <= '0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign tgt_ready = ready_r;
  assign j         = j_r;
  assign k         = k_r;
  assign done      = done_r;
  assign err       = err_r;
  assign retries   = retries_r;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed self-checking bench for jk_bank_driver with a behavioral JK bank
// that can inject faults (bit 0 ignores the first drive, bit 7 stuck at 0).
module tb_jk_bank_driver;

  logic       clk;
  logic       rst;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [7:0] tgt_data;
  logic       tgt_mode;
  logic [7:0] q_bank;
  logic [7:0] j;
  logic [7:0] k;
  logic       done;
  logic       err;
  logic [3:0] retries;

  logic       preset_en;
  logic [7:0] preset_val;
  logic       skip0;
  logic       stuck7;
  int         drive_cnt;

  int total;
  int passed;

  jk_bank_driver #(.WIDTH(8), .MAX_RETRY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_data  (tgt_data),
    .tgt_mode  (tgt_mode),
    .q         (q_bank),
    .j         (j),
    .k         (k),
    .done      (done),
    .err       (err),
    .retries   (retries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Next Q of the behavioral bank, including fault injection.
  function automatic logic [7:0] bank_next(input logic [7:0] cq, input logic [7:0] cj,
                                           input logic [7:0] ck, input logic hold0,
                                           input logic st7);
    logic [7:0] nq;
    for (int i = 0; i < 8; i++) begin
      case ({cj[i], ck[i]})
        2'b00:   nq[i] = cq[i];
        2'b01:   nq[i] = 1'b0;
        2'b10:   nq[i] = 1'b1;
        default: nq[i] = ~cq[i];
      endcase
    end
    if (hold0) nq[0] = cq[0];
    if (st7) nq[7] = 1'b0;
    return nq;
  endfunction

  // Behavioral JK bank clocked by the same edge as the driver.
  always @(posedge clk) begin
    if (preset_en) begin
      q_bank    <= preset_val;
      drive_cnt <= 0;
    end else begin
      if ((j | k) != 8'h00) drive_cnt <= drive_cnt + 1;
      q_bank <= bank_next(q_bank, j, k, skip0 && (drive_cnt == 0), stuck7);
    end
  end

  task automatic preset(input logic [7:0] v);
    preset_val = v;
    preset_en  = 1'b1;
    @(posedge clk);
    #1;
    preset_en = 1'b0;
  endtask

  // Offers a word and returns 1 time unit after the accept edge (DRIVE cycle).
  task automatic accept(input logic [7:0] d, input logic m);
    tgt_data  = d;
    tgt_mode  = m;
    tgt_valid = 1'b1;
    @(posedge clk);
    #1;
    tgt_valid = 1'b0;
    tgt_data  = 8'h00;
    tgt_mode  = 1'b0;
  endtask

  // Counts edges until done is seen after an edge; bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    total++; if (tgt_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", tgt_ready); else passed++;
    total++; if ({j, k} !== 16'h0000) $display("FAIL reset_jk got %h exp 0000", {j, k}); else passed++;
    total++; if ({done, err, retries} !== 6'd0) $display("FAIL reset_done_err_retries got %b exp 000000", {done, err, retries}); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_set_reset();
    int cyc;
    preset(8'h00);
    accept(8'hA5, 1'b0);
    total++; if (j !== 8'hA5 || k !== 8'h00) $display("FAIL setreset_jk got j=%h k=%h exp j=a5 k=00", j, k); else passed++;
    total++; if (tgt_ready !== 1'b0) $display("FAIL setreset_busy got %b exp 0", tgt_ready); else passed++;
    wait_done(cyc);
    // done is high in the third cycle counting the DRIVE cycle: two edges after accept
    total++; if (cyc !== 2) $display("FAIL setreset_latency got %0d exp 2", cyc); else passed++;
    total++; if (q_bank !== 8'hA5) $display("FAIL setreset_q got %h exp a5", q_bank); else passed++;
    total++; if ({err, retries, tgt_ready} !== 6'b0_0000_1) $display("FAIL setreset_status got %b exp 000001", {err, retries, tgt_ready}); else passed++;
    @(posedge clk);
    #1;
    total++; if ({done, err} !== 2'b00) $display("FAIL setreset_pulse got %b exp 00", {done, err}); else passed++;
  endtask

  task automatic test_toggle();
    int cyc;
    preset(8'hA5);
    accept(8'h5A, 1'b1);
    total++; if (j !== 8'hFF || k !== 8'hFF) $display("FAIL toggle_jk got j=%h k=%h exp ff ff", j, k); else passed++;
    @(posedge clk);
    #1;
    total++; if ({j, k} !== 16'h0000) $display("FAIL toggle_jk_released got %h exp 0000", {j, k}); else passed++;
    wait_done(cyc);
    total++; if (cyc !== 1 || q_bank !== 8'h5A || err !== 1'b0) $display("FAIL toggle_done got cyc=%0d q=%h err=%b exp 1 5a 0", cyc, q_bank, err); else passed++;
  endtask

  task automatic test_no_change();
    int cyc;
    preset(8'h3C);
    accept(8'h3C, 1'b0);
    total++; if ({j, k} !== 16'h0000) $display("FAIL nochange_jk got %h exp 0000", {j, k}); else passed++;
    wait_done(cyc);
    total++; if (cyc !== 2 || err !== 1'b0 || retries !== 4'd0) $display("FAIL nochange_done got cyc=%0d err=%b retries=%0d exp 2 0 0", cyc, err, retries); else passed++;
    total++; if (drive_cnt !== 0 || q_bank !== 8'h3C) $display("FAIL nochange_bank got drives=%0d q=%h exp 0 3c", drive_cnt, q_bank); else passed++;
  endtask

  task automatic test_retry();
    int cyc;
    skip0 = 1'b1;
    preset(8'h00);
    accept(8'h01, 1'b0);
    total++; if (j !== 8'h01 || k !== 8'h00) $display("FAIL retry_first_jk got j=%h k=%h exp 01 00", j, k); else passed++;
    @(posedge clk);
    #1;
    total++; if (q_bank !== 8'h00 || done !== 1'b0) $display("FAIL retry_check1 got q=%h done=%b exp 00 0", q_bank, done); else passed++;
    @(posedge clk);
    #1;
    total++; if (j !== 8'h01 || k !== 8'h00) $display("FAIL retry_second_jk got j=%h k=%h exp 01 00", j, k); else passed++;
    wait_done(cyc);
    // four edges from accept to done: accept..E4
    total++; if (cyc !== 2 || err !== 1'b0 || retries !== 4'd1) $display("FAIL retry_done got cyc=%0d err=%b retries=%0d exp 2 0 1", cyc, err, retries); else passed++;
    total++; if (q_bank !== 8'h01) $display("FAIL retry_q got %h exp 01", q_bank); else passed++;
    skip0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (retries !== 4'd1 || done !== 1'b0) $display("FAIL retry_hold got retries=%0d done=%b exp 1 0", retries, done); else passed++;
  endtask

  task automatic test_exhaust();
    int cyc;
    stuck7 = 1'b1;
    preset(8'h00);
    accept(8'h80, 1'b0);
    wait_done(cyc);
    // accept edge plus six edges: three DRIVE/CHECK pairs
    total++; if (cyc !== 6) $display("FAIL exhaust_latency got %0d exp 6", cyc); else passed++;
    total++; if ({err, retries, tgt_ready} !== 6'b1_0010_1) $display("FAIL exhaust_status got %b exp 100101", {err, retries, tgt_ready}); else passed++;
    total++; if (drive_cnt !== 3) $display("FAIL exhaust_drives got %0d exp 3", drive_cnt); else passed++;
    @(posedge clk);
    #1;
    total++; if ({done, err} !== 2'b00) $display("FAIL exhaust_pulse got %b exp 00", {done, err}); else passed++;
    stuck7 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    preset(8'h00);
    accept(8'h11, 1'b0);
    wait_done(cyc);
    total++; if (done !== 1'b1 || tgt_ready !== 1'b1) $display("FAIL b2b_first got done=%b ready=%b exp 1 1", done, tgt_ready); else passed++;
    accept(8'h22, 1'b0);
    total++; if (j !== 8'h22 || k !== 8'h11) $display("FAIL b2b_jk got j=%h k=%h exp 22 11", j, k); else passed++;
    wait_done(cyc);
    total++; if (cyc !== 2 || q_bank !== 8'h22 || err !== 1'b0) $display("FAIL b2b_second got cyc=%0d q=%h err=%b exp 2 22 0", cyc, q_bank, err); else passed++;
  endtask

  task automatic test_reset_in_check();
    int cyc;
    int seen;
    preset(8'h00);
    accept(8'h0F, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++; if ({j, k} !== 16'h0000 || done !== 1'b0 || tgt_ready !== 1'b1) $display("FAIL rstcheck_outputs got jk=%h done=%b ready=%b exp 0000 0 1", {j, k}, done, tgt_ready); else passed++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    total++; if (seen !== 0) $display("FAIL rstcheck_no_done got %0d exp 0", seen); else passed++;
    accept(8'hF0, 1'b0);
    wait_done(cyc);
    total++; if (cyc !== 2 || q_bank !== 8'hF0 || err !== 1'b0) $display("FAIL rstcheck_recover got cyc=%0d q=%h err=%b exp 2 f0 0", cyc, q_bank, err); else passed++;
  endtask

  initial begin
    total      = 0;
    passed     = 0;
    tgt_valid  = 1'b0;
    tgt_data   = 8'h00;
    tgt_mode   = 1'b0;
    preset_en  = 1'b0;
    preset_val = 8'h00;
    skip0      = 1'b0;
    stuck7     = 1'b0;
    test_reset();
    test_set_reset();
    test_toggle();
    test_no_change();
    test_retry();
    test_exhaust();
    test_back_to_back();
    test_reset_in_check();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
